// File: rtl/tone_generator.sv
// ---------------------------------------------------------------------------
// tone_generator
//
// Square-wave tone synthesiser sitting directly behind the sound controller.
// While EnableSound is high it produces a square wave whose half-period, in
// clk cycles, is preScaleValue.  It also produces signed 16-bit PCM samples
// at a fixed sample rate (one every SAMPLE_DIV clocks) for the codec
// serialiser.  A new preScaleValue is only picked up at a half-period
// boundary, so the waveform never glitches when the pitch changes.
//
// Optional build macro: VOLUME_RAMP_EN
//   When defined, the sample magnitude follows an envelope that ramps up by
//   RAMP_STEP per sample tick while playing and ramps down in a RELEASE
//   state after EnableSound drops.  When undefined, the magnitude switches
//   instantly between 0 and AMPLITUDE and there is no RELEASE state.
//
// Ports:
//   clk            system clock
//   reset          synchronous, active-high reset
//   EnableSound    level-sensitive tone request
//   preScaleValue  half-period length in clk cycles (32 bit)
//   square_out     registered square wave, 0 while idle or silent
//   sample_out     signed PCM sample, held between sample ticks
//   sample_valid   one-cycle strobe on every sample_out update
//   busy           high while the tone FSM is not idle
// ---------------------------------------------------------------------------
module tone_generator #(
    parameter int unsigned SAMPLE_DIV   = 1042,
    parameter logic [15:0] AMPLITUDE    = 16'd8192,
    parameter int unsigned MIN_PRESCALE = 2
`ifdef VOLUME_RAMP_EN
    ,
    parameter logic [15:0] RAMP_STEP    = 16'd64
`endif
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               EnableSound,
    input  logic [31:0]        preScaleValue,
    output logic               square_out,
    output logic signed [15:0] sample_out,
    output logic               sample_valid,
    output logic               busy
);

    localparam int CNT_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(SAMPLE_DIV - 1);
    localparam logic [31:0] MIN_HALF = 32'(MIN_PRESCALE);

`ifdef VOLUME_RAMP_EN
    typedef enum logic [1:0] {IDLE, PLAY, RELEASE} toneState_t;
`else
    typedef enum logic [1:0] {IDLE, PLAY} toneState_t;
`endif

    toneState_t state, stateNext;

    logic [CNT_W-1:0]   sampleCnt;
    logic               tick;
    logic [31:0]        halfCnt, halfCntNext;
    logic [31:0]        heldHalf, heldHalfNext;
    logic               phase, phaseNext;
    logic               silent, silentNext;
    logic               preScaleOk;
    logic               halfDone;
    logic [15:0]        mag;
    logic signed [15:0] sampleNext;

`ifdef VOLUME_RAMP_EN
    logic [15:0] envelope, envelopeNext;
    logic [16:0] envUp;
`endif

    assign tick       = (sampleCnt == TICK_LAST);
    assign silent     = (heldHalf < MIN_HALF);
    assign silentNext = (heldHalfNext < MIN_HALF);
    assign preScaleOk = (preScaleValue >= MIN_HALF);
    // Only evaluated while not silent, so heldHalf >= 2 and the subtraction
    // cannot wrap.
    assign halfDone   = (halfCnt == heldHalf - 32'd1);

    // Tone state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Next-state and half-period bookkeeping.  Entering PLAY always latches
    // a fresh half-period and starts on the high phase.  Inside PLAY the
    // pitch is only re-latched at a half-period boundary; while the latched
    // value is too small to play, preScaleValue is re-sampled every cycle so
    // a valid value restarts the tone cleanly.
    always_comb begin
        stateNext    = state;
        halfCntNext  = halfCnt;
        heldHalfNext = heldHalf;
        phaseNext    = phase;
        case (state)
            IDLE: begin
                if (EnableSound) begin
                    stateNext    = PLAY;
                    heldHalfNext = preScaleValue;
                    halfCntNext  = '0;
                    phaseNext    = 1'b1;
                end
            end
            PLAY: begin
                if (!EnableSound) begin
`ifdef VOLUME_RAMP_EN
                    stateNext = RELEASE;
`else
                    stateNext = IDLE;
`endif
                end else if (silent) begin
                    heldHalfNext = preScaleValue;
                    halfCntNext  = '0;
                    if (preScaleOk) begin
                        phaseNext = 1'b1;
                    end
                end else if (halfDone) begin
                    phaseNext    = ~phase;
                    halfCntNext  = '0;
                    heldHalfNext = preScaleValue;
                end else begin
                    halfCntNext = halfCnt + 32'd1;
                end
            end
`ifdef VOLUME_RAMP_EN
            RELEASE: begin
                if (EnableSound) begin
                    stateNext    = PLAY;
                    heldHalfNext = preScaleValue;
                    halfCntNext  = '0;
                    phaseNext    = 1'b1;
                end else if (envelope == '0) begin
                    stateNext = IDLE;
                end
            end
`endif
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

`ifdef VOLUME_RAMP_EN
    // Envelope moves one step per sample tick: up while playing (clamped at
    // AMPLITUDE), down while releasing (clamped at zero).
    always_comb begin
        envUp        = {1'b0, envelope} + {1'b0, RAMP_STEP};
        envelopeNext = envelope;
        if (tick) begin
            if (state == PLAY) begin
                envelopeNext = (envUp > {1'b0, AMPLITUDE}) ? AMPLITUDE : envUp[15:0];
            end else if (state == RELEASE) begin
                envelopeNext = (envelope > RAMP_STEP) ? (envelope - RAMP_STEP) : '0;
            end
        end
    end

    assign mag = ((state == IDLE) || silent) ? '0 : envelope;
`else
    assign mag = ((state == PLAY) && !silent) ? AMPLITUDE : '0;
`endif

    // Sample uses the phase held before this cycle's edge, so a boundary
    // coinciding with a tick reports the pre-toggle phase.
    assign sampleNext = phase ? mag : (~mag + 16'd1);

    // Datapath registers and outputs.  square_out and busy are registered
    // from next-state values so they line up with the state they describe.
    always_ff @(posedge clk) begin
        if (reset) begin
            sampleCnt    <= '0;
            halfCnt      <= '0;
            heldHalf     <= '0;
            phase        <= 1'b1;
            square_out   <= 1'b0;
            sample_out   <= '0;
            sample_valid <= 1'b0;
            busy         <= 1'b0;
`ifdef VOLUME_RAMP_EN
            envelope     <= '0;
`endif
        end else begin
            sampleCnt    <= tick ? '0 : (sampleCnt + CNT_W'(1));
            halfCnt      <= halfCntNext;
            heldHalf     <= heldHalfNext;
            phase        <= phaseNext;
            sample_valid <= tick;
            if (tick) begin
                sample_out <= sampleNext;
            end
            square_out   <= phaseNext && (stateNext == PLAY) && !silentNext;
            busy         <= (stateNext != IDLE);
`ifdef VOLUME_RAMP_EN
            envelope     <= envelopeNext;
`endif
        end
    end

endmodule

// File: doc/tone_generator.md
Name: tone_generator

Overview:
Square-wave tone synthesiser directly downstream of the sound controller. It consumes EnableSound and preScaleValue, where preScaleValue is the half-period length in clk cycles. It produces a 1-bit square wave and 16-bit signed PCM samples at a fixed sample rate for the audio codec serialiser. Frequency changes take effect only at half-period boundaries, so the waveform never glitches.

Parameters:
SAMPLE_DIV, 1042, clk cycles per output sample (50 MHz / 1042 ≈ 48 kHz)
AMPLITUDE, 16'd8192, peak magnitude of sample_out
MIN_PRESCALE, 2, preScaleValue below this is treated as silence
RAMP_STEP, 16'd64, envelope increment per sample tick (only with VOLUME_RAMP_EN)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
EnableSound  in  1  tone request from the sound controller, level-sensitive
preScaleValue  in  32  half-period in clk cycles
square_out  out  1  registered square wave, 0 when silent
sample_out  out  16  signed PCM sample, held between sample ticks
sample_valid  out  1  one-cycle strobe when sample_out updates
busy  out  1  high while the FSM is not in IDLE

Behaviour:
- Reset (sync, active-high) forces:
  - state = IDLE; all counters = 0; phase = 1; held_half = 0; envelope = 0.
  - square_out = 0, sample_out = 0, sample_valid = 0, busy = 0.
- Sample tick:
  - Free-running counter runs 0..SAMPLE_DIV-1 and wraps to 0.
  - tick is asserted when the counter equals SAMPLE_DIV-1.
  - sample_valid is a registered copy of tick, so the first strobe arrives at cycle SAMPLE_DIV after reset release.
  - Tick timing is independent of tone state.
- Tone FSM states: IDLE, PLAY, and RELEASE (RELEASE exists only with VOLUME_RAMP_EN).
  - IDLE -> PLAY when EnableSound=1. On that cycle: held_half <= preScaleValue, half_cnt <= 0, phase <= 1.
  - PLAY -> IDLE (or RELEASE with the macro) on the first cycle EnableSound=0.
  - RELEASE -> IDLE when envelope reaches 0.
  - RELEASE -> PLAY if EnableSound returns to 1. The envelope continues from its current value; held_half is reloaded from preScaleValue.
- Half-period counter (PLAY only):
  - half_cnt increments every clk.
  - When half_cnt == held_half-1: phase toggles, half_cnt <= 0, held_half <= preScaleValue (new frequency latched here only).
  - Mid-half-period changes to preScaleValue have no effect until the next boundary.
  - Compare held_half as a full 32-bit value; no truncation.
- Silence:
  - If held_half < MIN_PRESCALE, phase is frozen, square_out = 0 and sample magnitude = 0.
  - preScaleValue is re-sampled every cycle while in this condition; a valid value restarts the tone with half_cnt = 0 and phase = 1.
- Outputs:
  - square_out, registered: phase AND (state==PLAY) AND not silent.
  - sample_out, updated only on tick cycles (same cycle sample_valid rises):
    - mag = AMPLITUDE in PLAY, 0 in IDLE; envelope with the macro.
    - sample_out = +mag when phase=1, −mag (two's complement) when phase=0.
    - Held unchanged otherwise.
  - busy = (state != IDLE), registered.
- Simultaneous events: a half-period boundary and a tick in the same cycle use the phase value before the toggle.
- Reset mid-tone returns every output to its reset value on the next clk edge. No residual sample is emitted.

Optional Feature:
VOLUME_RAMP_EN
- Defined:
  - 16-bit envelope, +RAMP_STEP per tick in PLAY, saturating at AMPLITUDE.
  - −RAMP_STEP per tick in RELEASE, saturating at 0; RELEASE -> IDLE when envelope == 0.
  - mag = envelope.
  - square_out is unaffected and stays gated by state==PLAY.
- Undefined: RELEASE state and envelope are absent; mag steps instantly between 0 and AMPLITUDE.

Test Plan:
- Reset, then idle 3000 cycles -> square_out=0, busy=0, sample_valid pulses at cycles 1042 and 2084, sample_out=0.
- EnableSound=1, preScaleValue=500 -> square_out high 500 cycles, low 500, repeating; samples = +8192/−8192 (ramp off).
- preScaleValue changed 500->300 at cycle 200 of a half-period -> current half lasts 500 cycles, subsequent halves 300.
- preScaleValue=1 with EnableSound=1 -> busy=1, square_out=0, samples 0. Then preScaleValue=4 -> toggling every 4 cycles starting high.
- Macro on, AMPLITUDE=8192, RAMP_STEP=64 -> magnitude reaches 8192 after 128 ticks. Drop EnableSound -> 128 ticks of decay, then busy=0.
- Assert reset mid-PLAY with sample_out=−8192 -> next cycle all outputs 0, state IDLE.
